// File: rtl/seg7_ms_display.sv
// rtl/seg7_ms_display.sv - binary count to 3-digit multiplexed common-anode seven-segment display
// Sequential double-dabble conversion; digit scan paced by an external strobe.
module seg7_ms_display #(
   parameter int unsigned SCAN_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value,
   input  logic       scan_tick,
   output logic [2:0] an,
   output logic [6:0] seg,
   output logic       busy
);

   typedef enum logic {IDLE, CONV} state_t;

   localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

   state_t      state;
   logic [7:0]  last_val;
   logic [7:0]  bin;
   logic [11:0] bcd;
   logic [2:0]  iter;
   logic [3:0]  dig_h, dig_t, dig_o;
   logic [1:0]  scan_idx;
   logic [7:0]  div_cnt;

   logic [11:0] bcd_adj;
   logic [19:0] shifted;
   logic [3:0]  cur_digit;
   logic        blank;

   // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      shifted = {bcd_adj, bin} << 1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_val <= 8'd0;
         bin      <= 8'd0;
         bcd      <= 12'd0;
         iter     <= 3'd0;
         dig_h    <= 4'd0;
         dig_t    <= 4'd0;
         dig_o    <= 4'd0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (value != last_val) begin
                  last_val <= value;
                  bin      <= value;
                  bcd      <= 12'd0;
                  iter     <= 3'd0;
                  busy     <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               bcd  <= shifted[19:8];
               bin  <= shifted[7:0];
               iter <= iter + 3'd1;
               // Digits are only written once the final shift lands, never partially.
               if (iter == 3'd7) begin
                  dig_h <= shifted[19:16];
                  dig_t <= shifted[15:12];
                  dig_o <= shifted[11:8];
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_idx <= 2'd0;
         div_cnt  <= 8'd0;
      end else if (scan_tick) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
      end
   end

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   // Leading-zero blanking: ones digit is always lit.
   always_comb begin
      cur_digit = dig_o;
      blank     = 1'b0;
      case (scan_idx)
         2'd0: begin
            cur_digit = dig_o;
            blank     = 1'b0;
         end
         2'd1: begin
            cur_digit = dig_t;
            blank     = (dig_h == 4'd0) && (dig_t == 4'd0);
         end
         default: begin
            cur_digit = dig_h;
            blank     = (dig_h == 4'd0);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 3'b110;
         seg <= 7'b1000000;
      end else begin
         an  <= ~(3'b001 << scan_idx);
         seg <= blank ? 7'b1111111 : seg_code(cur_digit);
      end
   end

endmodule

// File: doc/seg7_ms_display.md
Name: seg7_ms_display

Overview:
- Downstream consumer of the 8-bit millisecond count (`cnt_ms`) and the 1 ms strobe (`ms`) produced by the timer/ms_counter pair.
- Converts the binary count to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a common-anode 3-digit seven-segment display, with leading-zero blanking.
- Digit scan is paced by the ms strobe, so no second prescaler is needed.

Parameters:
- SCAN_DIV, 1: number of scan_tick pulses per digit advance; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  8  binary count to display (connects to cnt_ms).
- scan_tick  input  1  single-cycle strobe (connects to ms).
- an  output  3  digit enables, one-hot, active-low; an[0]=ones, an[1]=tens, an[2]=hundreds.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset values (registered, first cycle after rst):
  - state=IDLE; last_val=0; digits H/T/O=0/0/0; scan_idx=0; div_cnt=0.
  - an=3'b110; seg=7'b1000000 (ones digit showing "0"); busy=0.
- Conversion FSM (IDLE, CONV):
  - IDLE: if value != last_val at an edge, capture value into last_val and into the shift register, clear the 12-bit BCD accumulator and iter=0, then go to CONV.
  - CONV: on each edge, add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1, then iter++.
  - The edge that performs the 8th shift (iter 7->8) writes H/T/O from the accumulator and returns to IDLE.
  - H/T/O therefore update exactly 8 edges after the capture edge. busy=1 for exactly those 8 cycles.
  - Changes to value during CONV are ignored. The first IDLE cycle re-compares value against last_val and restarts if they differ.
  - Range 0..255 only, so H is 0..2; there is no overflow case.
- Scan:
  - div_cnt counts scan_tick pulses from 0 to SCAN_DIV-1.
  - On a tick with div_cnt==SCAN_DIV-1: div_cnt=0 and scan_idx advances 0->1->2->0.
  - scan_tick has no effect while rst is high.
  - Scanning runs independently of the FSM. Digits shown mid-conversion are the previous H/T/O; H/T/O never show partial values.
- Output decode (registered; an/seg reflect scan_idx, H/T/O and blanking one cycle after they change):
  - an = ~(1<<scan_idx).
  - Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blanking (seg=7'b1111111): hundreds blanked when H==0; tens blanked when H==0 and T==0; ones never blanked.
- Reset mid-conversion: the FSM returns to IDLE, H/T/O=0, and the partial result is discarded. After rst drops, value!=0 triggers a fresh conversion on the next edge.

Test Plan:
- Reset then idle, value=0 held, scan_tick every 4 clks, SCAN_DIV=1 -> busy stays 0; an cycles 110,101,011 one step per tick; seg=1000000 when an=110 and 1111111 for the other digits.
- value 0->255 at edge E0 -> busy high for cycles E0..E7; H/T/O=2/5/5 after E8; scanned seg values are 0010010, 0010010, 0100100 for ones, tens, hundreds.
- value=7 -> ones shows 1111000; tens and hundreds blanked. value=100 -> ones 1000000, tens 1000000 (not blanked), hundreds 1111001.
- value=42, then value=199 two cycles after capture -> 42 displayed first, a second conversion starts immediately after; 1/9/9 final, with no intermediate values on H/T/O.
- SCAN_DIV=4 -> scan_idx advances only on every 4th scan_tick; non-tick cycles never advance div_cnt.
- rst asserted on 4th CONV cycle of value=200 -> next cycle busy=0, H/T/O=0, an=110; after release, 2/0/0 is displayed 9 edges later.
